// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: merges NUM_CH byte FIFOs onto one UART data input.
// Loads change only on tx_ready pulses; a watchdog catches a stalled UART.
module uart_tx_arbiter #(
   parameter int                NUM_CH     = 2,
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] IDLE_BYTE  = '0,
   parameter int                TIMEOUT    = 4096
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       rr_mode,
   input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
   input  logic [NUM_CH-1:0]          push_valid,
   input  logic [NUM_CH*DATA_W-1:0]   push_data,
   input  logic [NUM_CH-1:0]          flush,
   output logic [NUM_CH-1:0]          push_ready,
   input  logic                       tx_ready,
   output logic [DATA_W-1:0]          tx_bits,
   output logic                       busy,
   output logic [$clog2(NUM_CH)-1:0]  cur_ch,
   output logic                       timeout_err,
   output logic [15:0]                sent_count
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT) + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
   localparam logic [CH_W:0]    CH_NUM   = (CH_W + 1)'(NUM_CH);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_W-1:0] r_mem  [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr [NUM_CH];
   logic [PTR_W-1:0]  r_rptr [NUM_CH];
   logic [CNT_W-1:0]  r_cnt  [NUM_CH];
   logic [DATA_W-1:0] w_head [NUM_CH];

   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic [NUM_CH-1:0] w_avail;

   logic [CH_W-1:0]   r_rr_ptr;
   logic [CH_W-1:0]   w_sel;
   logic [CH_W-1:0]   w_sel_nxt;
   logic              w_found;

   logic              w_load;
   logic              w_to_idle;
   logic              w_done;
   logic              w_timeout;

   logic [WD_W-1:0]   r_wd;
   logic [DATA_W-1:0] r_tx_bits;
   logic [CH_W-1:0]   r_cur_ch;
   logic              r_timeout_err;
   logic [15:0]       r_sent_count;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_fifo
         // A flushed channel gives up its contents this cycle, so it
         // is neither written nor offered to the arbiter.
         assign w_full[gi]     = (r_cnt[gi] == CNT_FULL);
         assign w_push[gi]     = push_valid[gi] && !w_full[gi]
                                 && !flush[gi];
         assign w_avail[gi]    = (r_cnt[gi] != '0) && !flush[gi];
         assign w_pop[gi]      = w_load && (w_sel == CH_W'(gi));
         assign push_ready[gi] = !w_full[gi];
         assign w_head[gi]     = r_mem[gi][r_rptr[gi]];

         // Storage array: written on an accepted push, never reset.
         always_ff @(posedge clock) begin
            if (w_push[gi]) begin
               r_mem[gi][r_wptr[gi]] <= push_data[gi*DATA_W +: DATA_W];
            end
         end

         // Pointers and occupancy; flush clears like reset.
         always_ff @(posedge clock) begin
            if (reset || flush[gi]) begin
               r_wptr[gi] <= '0;
               r_rptr[gi] <= '0;
               r_cnt[gi]  <= '0;
            end else begin
               if (w_push[gi]) begin
                  r_wptr[gi] <= r_wptr[gi] + PTR_W'(1);
               end
               if (w_pop[gi]) begin
                  r_rptr[gi] <= r_rptr[gi] + PTR_W'(1);
               end
               if (w_push[gi] && !w_pop[gi]) begin
                  r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
               end else if (w_pop[gi] && !w_push[gi]) begin
                  r_cnt[gi] <= r_cnt[gi] - CNT_W'(1);
               end
            end
         end
      end
   endgenerate

   // Pick the channel to serve at the next load decision.
   always_comb begin : p_elig
      logic [CH_W:0] w_idx;
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      if (!rr_mode) begin
         if (int'(ch_sel) < NUM_CH) begin
            if (w_avail[ch_sel]) begin
               w_found = 1'b1;
               w_sel   = ch_sel;
            end
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (CH_W + 1)'(k);
            if (w_idx >= CH_NUM) begin
               w_idx = w_idx - CH_NUM;
            end
            if (!w_found && w_avail[w_idx[CH_W-1:0]]) begin
               w_found = 1'b1;
               w_sel   = w_idx[CH_W-1:0];
            end
         end
      end
      w_sel_nxt = (w_sel == CH_LAST) ? '0 : w_sel + CH_W'(1);
   end

   // Next state and load/idle/timeout decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_to_idle   = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (tx_ready && w_found) begin
               w_load      = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               w_done = 1'b1;
               if (w_found) begin
                  w_load = 1'b1;
               end else begin
                  w_to_idle   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else if (r_wd == WD_MAX) begin
               w_timeout   = 1'b1;
               w_to_idle   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output byte, channel tag and round-robin pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tx_bits <= IDLE_BYTE;
         r_cur_ch  <= '0;
         r_rr_ptr  <= '0;
      end else if (w_load) begin
         r_tx_bits <= w_head[w_sel];
         r_cur_ch  <= w_sel;
         if (rr_mode) begin
            r_rr_ptr <= w_sel_nxt;
         end
      end else if (w_to_idle) begin
         r_tx_bits <= IDLE_BYTE;
      end
   end

   // Watchdog restarts on every tx_ready and whenever not sending.
   always_ff @(posedge clock) begin
      if (reset || tx_ready || r_state != S_SEND) begin
         r_wd <= '0;
      end else begin
         r_wd <= r_wd + WD_W'(1);
      end
   end

   // Sticky timeout flag and saturating completed-byte counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_timeout_err <= 1'b0;
         r_sent_count  <= '0;
      end else begin
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
         if (w_done && r_sent_count != 16'hFFFF) begin
            r_sent_count <= r_sent_count + 16'd1;
         end
      end
   end

   assign tx_bits     = r_tx_bits;
   assign busy        = (r_state == S_SEND);
   assign cur_ch      = r_cur_ch;
   assign timeout_err = r_timeout_err;
   assign sent_count  = r_sent_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the UART channel arbiter.
// A queue-based model predicts each load; the DUT result is compared after it.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        rr_mode;
   logic        ch_sel;
   logic [1:0]  push_valid;
   logic [15:0] push_data;
   logic [1:0]  flush;
   logic [1:0]  push_ready;
   logic        tx_ready;
   logic [7:0]  tx_bits;
   logic        busy;
   logic        cur_ch;
   logic        timeout_err;
   logic [15:0] sent_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [7:0]  bits;
      logic        cur;
      logic        busy;
      logic [15:0] sent;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  mq[2][$];
   int          m_rr;
   int          m_cur;
   logic [7:0]  m_bits;
   logic        m_busy;
   logic [15:0] m_sent;

   uart_tx_arbiter #(
      .NUM_CH     (2),
      .DATA_W     (8),
      .FIFO_DEPTH (4),
      .IDLE_BYTE  (8'h00),
      .TIMEOUT    (16)
   ) dut (
      .clock       (clk),
      .reset       (reset),
      .rr_mode     (rr_mode),
      .ch_sel      (ch_sel),
      .push_valid  (push_valid),
      .push_data   (push_data),
      .flush       (flush),
      .push_ready  (push_ready),
      .tx_ready    (tx_ready),
      .tx_bits     (tx_bits),
      .busy        (busy),
      .cur_ch      (cur_ch),
      .timeout_err (timeout_err),
      .sent_count  (sent_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq[0].delete();
      mq[1].delete();
      sb.delete();
      m_rr   = 0;
      m_cur  = 0;
      m_bits = 8'h00;
      m_busy = 1'b0;
      m_sent = 16'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      tx_ready = 1'b0;
      push_valid = '0;
      flush = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic push(input int ch, input logic [7:0] d);
      push_valid[ch] = 1'b1;
      push_data[ch*8 +: 8] = d;
      if (mq[ch].size() < 4) mq[ch].push_back(d);
      @(posedge clk);
      @(negedge clk);
      push_valid[ch] = 1'b0;
   endtask

   task automatic push2(input logic [7:0] d0, input logic [7:0] d1);
      push_valid = 2'b11;
      push_data = {d1, d0};
      if (mq[0].size() < 4) mq[0].push_back(d0);
      if (mq[1].size() < 4) mq[1].push_back(d1);
      @(posedge clk);
      @(negedge clk);
      push_valid = 2'b00;
   endtask

   task automatic pulse();
      int c;
      c = -1;
      tx_ready = 1'b1;
      if (m_busy && m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
      if (!rr_mode) begin
         if (mq[ch_sel].size() > 0) c = int'(ch_sel);
      end else begin
         for (int k = 0; k < 2; k++) begin
            int j;
            j = (m_rr + k) % 2;
            if (c < 0 && mq[j].size() > 0) c = j;
         end
      end
      if (c >= 0) begin
         m_bits = mq[c].pop_front();
         m_cur  = c;
         m_busy = 1'b1;
         if (rr_mode) m_rr = (c + 1) % 2;
      end else if (m_busy) begin
         m_bits = 8'h00;
         m_busy = 1'b0;
      end
      sb.push_back('{m_bits, m_cur[0], m_busy, m_sent});
      @(posedge clk);
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      n_checks++;
      if (tx_bits !== 8'h00 || busy !== 1'b0 || cur_ch !== 1'b0 ||
          timeout_err !== 1'b0 || sent_count !== 16'd0 ||
          push_ready !== 2'b11) begin
         n_errors++;
         $display("FAIL reset_vals: tx=%h busy=%b cur=%b to=%b sent=%0d pr=%b",
                  tx_bits, busy, cur_ch, timeout_err, sent_count, push_ready);
      end
      for (int i = 0; i < 3; i++) begin
         pulse();
         e = sb.pop_front();
         n_checks++;
         if (tx_bits !== e.bits || busy !== e.busy || sent_count !== e.sent) begin
            n_errors++;
            $display("FAIL idle_pulse%0d: tx=%h busy=%b sent=%0d want %h %b %0d",
                     i, tx_bits, busy, sent_count, e.bits, e.busy, e.sent);
         end
      end
   endtask

   task automatic test_fixed_sel();
      exp_t e;
      rr_mode = 1'b0;
      ch_sel = 1'b1;
      push2(8'h11, 8'h22);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) ch_sel = 1'b0;
         pulse();
         e = sb.pop_front();
         n_checks++;
         if (tx_bits !== e.bits || cur_ch !== e.cur || busy !== e.busy ||
             sent_count !== e.sent) begin
            n_errors++;
            $display("FAIL fixed%0d: tx=%h cur=%b busy=%b sent=%0d want %h %b %b %0d",
                     i, tx_bits, cur_ch, busy, sent_count,
                     e.bits, e.cur, e.busy, e.sent);
         end
      end
      n_checks++;
      if (sent_count !== 16'd2) begin
         n_errors++;
         $display("FAIL fixed_count: sent=%0d want 2", sent_count);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      logic [15:0] base;
      logic [7:0]  want [5];
      want = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'h00};
      base = sent_count;
      rr_mode = 1'b1;
      push2(8'hA1, 8'hB1);
      push2(8'hA2, 8'hB2);
      for (int i = 0; i < 5; i++) begin
         pulse();
         e = sb.pop_front();
         n_checks++;
         if (tx_bits !== e.bits || tx_bits !== want[i] || cur_ch !== e.cur ||
             busy !== e.busy || sent_count !== e.sent) begin
            n_errors++;
            $display("FAIL rr%0d: tx=%h cur=%b busy=%b sent=%0d want %h %b %b %0d",
                     i, tx_bits, cur_ch, busy, sent_count,
                     e.bits, e.cur, e.busy, e.sent);
         end
      end
      n_checks++;
      if (sent_count !== base + 16'd4) begin
         n_errors++;
         $display("FAIL rr_count: sent=%0d want %0d", sent_count, base + 16'd4);
      end
   endtask

   task automatic test_full();
      exp_t e;
      rr_mode = 1'b0;
      ch_sel = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(0, 8'h31 + 8'(i));
         if (i == 2 || i == 3) begin
            n_checks++;
            if (push_ready[0] !== (i == 2)) begin
               n_errors++;
               $display("FAIL full_ready%0d: push_ready0=%b want %b",
                        i, push_ready[0], (i == 2));
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         pulse();
         e = sb.pop_front();
         n_checks++;
         if (tx_bits !== e.bits || cur_ch !== e.cur || busy !== e.busy ||
             sent_count !== e.sent) begin
            n_errors++;
            $display("FAIL drain%0d: tx=%h cur=%b busy=%b sent=%0d want %h %b %b %0d",
                     i, tx_bits, cur_ch, busy, sent_count,
                     e.bits, e.cur, e.busy, e.sent);
         end
      end
      n_checks++;
      if (push_ready !== 2'b11) begin
         n_errors++;
         $display("FAIL full_after: push_ready=%b want 11", push_ready);
      end
   endtask

   task automatic test_flush();
      exp_t e;
      rr_mode = 1'b0;
      ch_sel = 1'b0;
      push(0, 8'h51);
      push(0, 8'h52);
      flush[0] = 1'b1;
      push_valid[0] = 1'b1;
      push_data[7:0] = 8'h77;
      mq[0].delete();
      @(posedge clk);
      @(negedge clk);
      flush[0] = 1'b0;
      push_valid[0] = 1'b0;
      n_checks++;
      if (push_ready[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_ready: push_ready0=%b want 1", push_ready[0]);
      end
      pulse();
      e = sb.pop_front();
      n_checks++;
      if (tx_bits !== e.bits || busy !== e.busy || sent_count !== e.sent) begin
         n_errors++;
         $display("FAIL flush_pulse: tx=%h busy=%b sent=%0d want %h %b %0d",
                  tx_bits, busy, sent_count, e.bits, e.busy, e.sent);
      end
   endtask

   task automatic test_mode_change();
      exp_t e;
      rr_mode = 1'b0;
      ch_sel = 1'b0;
      push2(8'hC0, 8'hD1);
      for (int i = 0; i < 3; i++) begin
         pulse();
         e = sb.pop_front();
         n_checks++;
         if (tx_bits !== e.bits || cur_ch !== e.cur || busy !== e.busy ||
             sent_count !== e.sent) begin
            n_errors++;
            $display("FAIL mode%0d: tx=%h cur=%b busy=%b sent=%0d want %h %b %b %0d",
                     i, tx_bits, cur_ch, busy, sent_count,
                     e.bits, e.cur, e.busy, e.sent);
         end
         if (i == 0) begin
            ch_sel = 1'b1;
            repeat (3) @(negedge clk);
            n_checks++;
            if (tx_bits !== 8'hC0 || busy !== 1'b1 || cur_ch !== 1'b0) begin
               n_errors++;
               $display("FAIL mode_hold: tx=%h busy=%b cur=%b want c0 1 0",
                        tx_bits, busy, cur_ch);
            end
         end
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      rr_mode = 1'b0;
      ch_sel = 1'b0;
      push(0, 8'hE5);
      pulse();
      e = sb.pop_front();
      n_checks++;
      if (tx_bits !== e.bits || busy !== e.busy || sent_count !== e.sent) begin
         n_errors++;
         $display("FAIL to_load: tx=%h busy=%b sent=%0d want %h %b %0d",
                  tx_bits, busy, sent_count, e.bits, e.busy, e.sent);
      end
      repeat (15) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL to_early: to=%b busy=%b want 0 1", timeout_err, busy);
      end
      @(posedge clk);
      @(negedge clk);
      m_busy = 1'b0;
      m_bits = 8'h00;
      n_checks++;
      if (timeout_err !== 1'b1 || tx_bits !== 8'h00 || busy !== 1'b0 ||
          sent_count !== m_sent) begin
         n_errors++;
         $display("FAIL to_fire: to=%b tx=%h busy=%b sent=%0d want 1 00 0 %0d",
                  timeout_err, tx_bits, busy, sent_count, m_sent);
      end
      do_reset();
      n_checks++;
      if (timeout_err !== 1'b0 || sent_count !== 16'd0) begin
         n_errors++;
         $display("FAIL to_clear: to=%b sent=%0d want 0 0", timeout_err, sent_count);
      end
   endtask

   task automatic test_reset_mid_send();
      exp_t e;
      rr_mode = 1'b1;
      push2(8'h61, 8'h62);
      pulse();
      e = sb.pop_front();
      n_checks++;
      if (tx_bits !== e.bits || cur_ch !== e.cur || busy !== e.busy) begin
         n_errors++;
         $display("FAIL rst_load: tx=%h cur=%b busy=%b want %h %b %b",
                  tx_bits, cur_ch, busy, e.bits, e.cur, e.busy);
      end
      do_reset();
      n_checks++;
      if (tx_bits !== 8'h00 || busy !== 1'b0 || cur_ch !== 1'b0 ||
          sent_count !== 16'd0 || push_ready !== 2'b11) begin
         n_errors++;
         $display("FAIL rst_mid: tx=%h busy=%b cur=%b sent=%0d pr=%b",
                  tx_bits, busy, cur_ch, sent_count, push_ready);
      end
      pulse();
      e = sb.pop_front();
      n_checks++;
      if (tx_bits !== e.bits || busy !== e.busy) begin
         n_errors++;
         $display("FAIL rst_empty: tx=%h busy=%b want %h %b",
                  tx_bits, busy, e.bits, e.busy);
      end
   endtask

   initial begin
      reset = 1'b1;
      rr_mode = 1'b0;
      ch_sel = 1'b0;
      push_valid = '0;
      push_data = '0;
      flush = '0;
      tx_ready = 1'b0;
      model_reset();
      test_reset();
      test_fixed_sel();
      test_round_robin();
      test_full();
      test_flush();
      test_mode_change();
      test_timeout();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Parametrised successor to the fixed two-way manual/auto `dataIn_bits` mux in front of the UART. It merges NUM_CH byte-producing command sources into the single UART `io_dataIn_bits` input. Each channel has its own FIFO. Service is either fixed-select or round-robin. `tx_bits` changes only on UART byte boundaries, marked by the `io_dataIn_ready` pulse. The block runs on the UART clock, and a watchdog flags a stalled UART.

Parameters:
NUM_CH, 2, number of command source channels (2..8)
DATA_W, 8, byte width
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
IDLE_BYTE, 8'h00, byte driven when nothing is pending (ignored by the game)
TIMEOUT, 4096, clock cycles allowed between tx_ready pulses while sending

Ports:
clock  in  1  UART clock (16x baud)
reset  in  1  synchronous, active-high
rr_mode  in  1  0 = fixed select via ch_sel; 1 = round-robin
ch_sel  in  $clog2(NUM_CH)  channel served when rr_mode=0
push_valid  in  NUM_CH  per-channel byte push strobe
push_data  in  NUM_CH*DATA_W  channel i byte at [i*DATA_W +: DATA_W]
flush  in  NUM_CH  per-channel FIFO clear
push_ready  out  NUM_CH  channel FIFO not full
tx_ready  in  1  one-cycle pulse from UART after a byte is transmitted
tx_bits  out  DATA_W  to UART io_dataIn_bits
busy  out  1  high in SEND state
cur_ch  out  $clog2(NUM_CH)  channel whose byte is in tx_bits
timeout_err  out  1  sticky watchdog flag
sent_count  out  16  bytes completed, saturates at 16'hFFFF

Behaviour:
Reset values:
- All FIFOs empty; push_ready all 1.
- tx_bits=IDLE_BYTE, busy=0, cur_ch=0, timeout_err=0, sent_count=0.
- Round-robin pointer=0; state IDLE.

FIFOs:
- Push accepted when push_valid[i] && !full[i]. A push while full is dropped silently.
- flush[i] empties FIFO i in the same cycle and wins over a simultaneous push to i.
- Push and pop on the same FIFO in one cycle are both performed and the count is unchanged.
- A byte pushed at cycle t is eligible from cycle t+1.
- Full when count==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Eligibility:
- rr_mode=0: only channel ch_sel is eligible, and only if its FIFO is non-empty.
- rr_mode=1: first non-empty channel searching from rr_ptr upward, wrapping at NUM_CH.

Load rule:
- tx_bits, cur_ch and the state update only in a cycle where tx_ready=1, or on timeout.
- New values are visible the following cycle.

State machine (IDLE, SEND):
- IDLE, tx_ready=1, eligible channel c exists: pop head of c into tx_bits, cur_ch<=c, go to SEND.
  - If rr_mode=1, rr_ptr<=(c+1) mod NUM_CH.
- IDLE, tx_ready=1, nothing eligible: tx_bits stays IDLE_BYTE.
- IDLE, tx_ready=0: hold.
- SEND, tx_ready=1: increment sent_count (saturating).
  - If a channel is eligible: pop and load it back-to-back and stay in SEND.
  - Otherwise: tx_bits<=IDLE_BYTE, go to IDLE.
- Watchdog in SEND:
  - Counter resets on every tx_ready and on entry to SEND.
  - When it reaches TIMEOUT-1 without tx_ready: timeout_err<=1, tx_bits<=IDLE_BYTE, go to IDLE.
  - The byte is discarded and is not counted.
- timeout_err clears only on reset.

Mode and select changes:
- An rr_mode or ch_sel change mid-SEND does not abort the byte in flight; it takes effect at the next load decision.

Reset mid-SEND:
- The byte is abandoned; all state returns to reset values on the next edge.

Test Plan:
- Reset, then 3 tx_ready pulses with no pushes -> tx_bits=8'h00, busy=0, sent_count=0 throughout.
- rr_mode=0, ch_sel=1; push 8'h11 to ch0 and 8'h22 to ch1; pulse tx_ready -> next cycle tx_bits=8'h22, cur_ch=1, busy=1. Further pulses -> 8'h00 then IDLE; ch0 still holds 8'h11; sent_count=1.
- rr_mode=1, NUM_CH=2; ch0 holds A1,A2 and ch1 holds B1,B2; 5 tx_ready pulses -> tx_bits sequence A1,B1,A2,B2,00; sent_count=4.
- Push 5 bytes to ch0 (FIFO_DEPTH=4) without tx_ready -> push_ready[0]=0 after the 4th push; 5th byte dropped. Drain -> exactly 4 bytes emitted, in order.
- flush[0] and push_valid[0] in the same cycle on a 2-entry FIFO -> FIFO empty, push_ready[0]=1, no ch0 byte emitted.
- TIMEOUT=16; load a byte, then hold tx_ready=0 for 16 cycles -> timeout_err=1, tx_bits=8'h00, busy=0, sent_count unchanged. Reset -> timeout_err=0.
